fp_align_pipe: RTL and testbench
================================

Name: fp_align_pipe

Overview:
- Parametrised, pipelined successor to the combinational mantissa aligner in the FP adder datapath.
- Takes two operands' mantissas and exponents and computes the exponent difference internally.
- Swaps the operands so the larger-exponent mantissa passes unshifted, then right-shifts the smaller one with guard/round bits and a sticky bit.
- Sits between operand unpack and the mantissa adder. Uses valid/ready handshakes on both sides, has 2-cycle latency, and accepts 1 operation per cycle.

Parameters:
- MANT_W, 8, mantissa width, hidden bit included.
- EXP_W, 4, exponent width, unsigned biased.
- EXT_W, MANT_W+2, aligned-mantissa width: mantissa plus guard and round bits. Derived; not overridable.

Ports:
- clk  in  1  clock. All logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair presented.
- in_ready  out  1  block accepts the pair this cycle.
- in_x_mant  in  MANT_W  operand X mantissa.
- in_x_exp  in  EXP_W  operand X exponent.
- in_y_mant  in  MANT_W  operand Y mantissa.
- in_y_exp  in  EXP_W  operand Y exponent.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_big_mant  out  MANT_W  mantissa of the larger-exponent operand, unshifted.
- out_small_ext  out  EXT_W  smaller operand: {mant, 2'b00} shifted right.
- out_sticky  out  1  OR of all bits shifted out below the round bit.
- out_exp  out  EXP_W  larger exponent (common exponent).
- out_swapped  out  1  1 when Y was the larger-exponent operand.

Behaviour:
- Reset, synchronous and active-high: on a clk edge with rst=1:
  - s1_valid, s2_valid and out_valid go to 0.
  - All data output registers go to 0.
  - in_ready is 1 in the first cycle after reset.
  - In-flight operations are discarded with no partial output.
- Transfer rules:
  - An input transfer happens on an edge where in_valid && in_ready.
  - An output transfer happens on an edge where out_valid && out_ready.
- Pipeline control:
  - adv2 = !s2_valid || out_ready
  - adv1 = !s1_valid || adv2
  - in_ready = adv1 (combinational from out_ready; no other comb path input->output).
- Stage 1, registered when adv1:
  - If x_exp >= y_exp: big=X, small=Y, swapped=0. Otherwise big=Y, small=X, swapped=1.
  - Tie (equal exponents) resolves to X as big.
  - d = big_exp - small_exp, unsigned EXP_W bits; never negative after the swap.
  - s1_valid <= in_valid.
- Stage 2, registered when adv2:
  - ext = {small_mant, 2'b00}.
  - If d < EXT_W: small_ext = ext >> d, and sticky = |(ext & ((1<<d)-1)).
  - If d >= EXT_W (saturation): small_ext = 0 and sticky = |small_mant.
  - Pass through big_mant, exp and swapped unchanged.
  - s2_valid <= s1_valid.
- Latency and throughput:
  - A result appears exactly 2 edges after the input transfer when out_ready is held at 1.
  - Throughput is 1 result per cycle.
- Backpressure:
  - While out_valid && !out_ready, all out_* signals hold stable.
  - Stage 1 holds once it is full.
  - in_ready=0 when both stages are full.
  - No operation is dropped or duplicated.
- Simultaneous events: a full pipeline with out_ready=1 accepts a new input in the same cycle.
- Zero mantissa: a small mantissa of 0 gives small_ext=0 and sticky=0 for any d.

Decomposition:
- Package fp_align_pkg holds:
  - the EXT_W derivation helper;
  - an align_res_t struct {big_mant, small_ext, sticky, exp, swapped}, parametrised through localparams;
  - the GRS bit-position constants.
- Sub-module sticky_shifter: combinational parametrised right shift with sticky and saturation.
  - Ports: in[W], amt[EXP_W], out[W], sticky.
  - Instantiated in stage 2.

Test Plan (MANT_W=8, EXP_W=4, EXT_W=10):
- Basic shift: X=0xB0/e5, Y=0xC8/e3 -> after 2 cycles big=0xB0, small_ext=0x0C8, sticky=0, exp=5, swapped=0.
- Swap: X=0x90/e2, Y=0xA0/e6 -> big=0xA0, small_ext={0x90,00}>>4=0x024, sticky=0, exp=6, swapped=1.
- Equal exponents: X=0x80/e7, Y=0xFF/e7 -> big=0x80, small_ext=0x3FC, sticky=0, swapped=0.
- Sticky and saturation:
  - Y=0x81, d=9 -> small_ext=0x001, sticky=1.
  - Y=0x81, d=12 -> small_ext=0, sticky=1.
  - Y=0x00, d=12 -> small_ext=0, sticky=0.
- Backpressure: stream 4 ops with out_ready=0 for cycles 2-5 -> in_ready drops after 2 accepted, outputs stay stable, all 4 results emerge in order with none lost or duplicated.
- Mid-operation reset: rst=1 for 1 cycle with both stages full -> out_valid=0 and outputs=0 next cycle, in_ready=1, and no stale result appears afterward.

Source files
------------

// File: rtl/fp_align_pkg.sv
// fp_align_pkg: shared widths, GRS layout and result type for the FP mantissa aligner
package fp_align_pkg;
    localparam int G_POS = 1;
    localparam int R_POS = 0;
    localparam int GRS_W = G_POS - R_POS + 1;
    localparam int DEF_MANT_W = 8;
    localparam int DEF_EXP_W = 4;
    function automatic int ext_w(input int mant_w);
        return mant_w + GRS_W;
    endfunction
    localparam int DEF_EXT_W = ext_w(DEF_MANT_W);
    typedef struct packed {
        logic [DEF_MANT_W-1:0] big_mant;
        logic [DEF_EXT_W-1:0]  small_ext;
        logic                  sticky;
        logic [DEF_EXP_W-1:0]  exp;
        logic                  swapped;
    } align_res_t;
endpackage

// File: rtl/fp_align_pipe_sticky_shifter.sv
// sticky_shifter: right shift with sticky collection, saturating to zero once amt >= W
module sticky_shifter #(
    parameter int W  = 10,
    parameter int AW = 4
) (
    input  logic [W-1:0]  in,
    input  logic [AW-1:0] amt,
    output logic [W-1:0]  out,
    output logic          sticky
);
    logic sat;
    always_comb begin
        sat    = int'(amt) >= W;
        out    = sat ? '0 : in >> amt;
        sticky = sat ? |in : |(in & ~({W{1'b1}} << amt));
    end
endmodule

// File: rtl/fp_align_pipe.sv
// fp_align_pipe: two-stage valid/ready aligner: swap by exponent, then shift the smaller mantissa
module fp_align_pipe import fp_align_pkg::*; #(
    parameter int   MANT_W = DEF_MANT_W,
    parameter int   EXP_W  = DEF_EXP_W,
    localparam int  EXT_W  = ext_w(MANT_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] in_x_mant,
    input  logic [EXP_W-1:0]  in_x_exp,
    input  logic [MANT_W-1:0] in_y_mant,
    input  logic [EXP_W-1:0]  in_y_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_big_mant,
    output logic [EXT_W-1:0]  out_small_ext,
    output logic              out_sticky,
    output logic [EXP_W-1:0]  out_exp,
    output logic              out_swapped
);
    logic adv1, adv2, s1_valid, s2_valid, s1_swapped, x_big, sh_sticky;
    logic [MANT_W-1:0] s1_big, s1_small;
    logic [EXP_W-1:0] s1_exp, s1_d;
    logic [EXT_W-1:0] sh_out;
    assign adv2      = !s2_valid || out_ready;
    assign adv1      = !s1_valid || adv2;
    assign in_ready  = adv1;
    assign out_valid = s2_valid;
    assign x_big     = in_x_exp >= in_y_exp;
    sticky_shifter #(.W(EXT_W), .AW(EXP_W)) u_shift (
        .in     ({s1_small, {GRS_W{1'b0}}}),
        .amt    (s1_d),
        .out    (sh_out),
        .sticky (sh_sticky)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_big        <= '0;
            s1_small      <= '0;
            s1_exp        <= '0;
            s1_d          <= '0;
            s1_swapped    <= 1'b0;
            s2_valid      <= 1'b0;
            out_big_mant  <= '0;
            out_small_ext <= '0;
            out_sticky    <= 1'b0;
            out_exp       <= '0;
            out_swapped   <= 1'b0;
        end else begin
            if (adv1) begin
                s1_valid   <= in_valid;
                s1_big     <= x_big ? in_x_mant : in_y_mant;
                s1_small   <= x_big ? in_y_mant : in_x_mant;
                s1_exp     <= x_big ? in_x_exp : in_y_exp;
                s1_d       <= x_big ? in_x_exp - in_y_exp : in_y_exp - in_x_exp;
                s1_swapped <= !x_big;
            end
            if (adv2) begin
                s2_valid      <= s1_valid;
                out_big_mant  <= s1_big;
                out_small_ext <= sh_out;
                out_sticky    <= sh_sticky;
                out_exp       <= s1_exp;
                out_swapped   <= s1_swapped;
            end
        end
    end
endmodule

// File: tb/tb_fp_align_pipe.sv
// tb_fp_align_pipe: directed vectors plus a scoreboard model checking every output transfer
module tb_fp_align_pipe;
    typedef struct packed {
        logic [7:0] big;
        logic [9:0] se;
        logic       st;
        logic [3:0] e;
        logic       sw;
    } res_t;

    logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
    logic [7:0] in_x_mant = 0, in_y_mant = 0;
    logic [3:0] in_x_exp = 0, in_y_exp = 0;
    logic in_ready, out_valid, out_sticky, out_swapped;
    logic [7:0] out_big_mant;
    logic [9:0] out_small_ext;
    logic [3:0] out_exp;
    int tests = 0, fails = 0, n_in = 0, n_out = 0, n_drop = 0, cyc = 0;
    res_t q[$];

    fp_align_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_x_mant(in_x_mant), .in_x_exp(in_x_exp), .in_y_mant(in_y_mant), .in_y_exp(in_y_exp),
        .out_valid(out_valid), .out_ready(out_ready), .out_big_mant(out_big_mant),
        .out_small_ext(out_small_ext), .out_sticky(out_sticky), .out_exp(out_exp),
        .out_swapped(out_swapped)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic res_t model(input int xm, input int xe, input int ym, input int ye);
        res_t r;
        int bm, sm, be, sme, d, ext;
        r.sw = xe < ye;
        bm = r.sw ? ym : xm;
        sm = r.sw ? xm : ym;
        be = r.sw ? ye : xe;
        sme = r.sw ? xe : ye;
        d = be - sme;
        ext = sm * 4;
        r.big = bm[7:0];
        r.e = be[3:0];
        if (d < 10) begin
            r.se = 10'(ext / (1 << d));
            r.st = (ext % (1 << d)) != 0;
        end else begin
            r.se = '0;
            r.st = sm != 0;
        end
        return r;
    endfunction

    function automatic res_t dut_out();
        return {out_big_mant, out_small_ext, out_sticky, out_exp, out_swapped};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            n_drop += q.size();
            q.delete();
        end else begin
            if (out_valid) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL mon_unexpected: got 0x%0h expected no output", dut_out());
                end else begin
                    if (dut_out() !== q[0]) begin
                        fails++;
                        $display("FAIL mon_out: got 0x%0h expected 0x%0h", dut_out(), q[0]);
                    end
                    if (out_ready) begin
                        void'(q.pop_front());
                        n_out++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(in_x_mant, in_x_exp, in_y_mant, in_y_exp));
                n_in++;
            end
        end
    end

    task automatic send(input logic [7:0] xm, input logic [3:0] xe, input logic [7:0] ym, input logic [3:0] ye);
        bit ok = 0;
        in_x_mant = xm; in_x_exp = xe; in_y_mant = ym; in_y_exp = ye;
        in_valid = 1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic directed(input string name, input logic [7:0] xm, input logic [3:0] xe,
                            input logic [7:0] ym, input logic [3:0] ye, input res_t want);
        send(xm, xe, ym, ye);
        @(negedge clk);
        chk({name, "_early"}, out_valid, 0);
        @(negedge clk);
        chk({name, "_valid"}, out_valid, 1);
        chk({name, "_res"}, dut_out(), want);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        #1;
        chk("drain", q.size(), 0);
    endtask

    initial begin
        res_t snap;
        int c0, o0;
        chk("model_basic", model(8'hB0, 5, 8'hC8, 3), {8'hB0, 10'h0C8, 1'b0, 4'd5, 1'b0});
        chk("model_swap", model(8'h90, 2, 8'hA0, 6), {8'hA0, 10'h024, 1'b0, 4'd6, 1'b1});
        chk("model_sat", model(8'h80, 12, 8'h81, 0), {8'h80, 10'h000, 1'b1, 4'd12, 1'b0});

        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_data", dut_out(), 0);
        @(posedge clk);
        #1;

        directed("basic", 8'hB0, 5, 8'hC8, 3, {8'hB0, 10'h0C8, 1'b0, 4'd5, 1'b0});
        directed("swap", 8'h90, 2, 8'hA0, 6, {8'hA0, 10'h024, 1'b0, 4'd6, 1'b1});
        directed("equal", 8'h80, 7, 8'hFF, 7, {8'h80, 10'h3FC, 1'b0, 4'd7, 1'b0});
        directed("d9", 8'h80, 9, 8'h81, 0, {8'h80, 10'h001, 1'b1, 4'd9, 1'b0});
        directed("d10", 8'h80, 10, 8'h81, 0, {8'h80, 10'h000, 1'b1, 4'd10, 1'b0});
        directed("d12", 8'h80, 12, 8'h81, 0, {8'h80, 10'h000, 1'b1, 4'd12, 1'b0});
        directed("zero", 8'h80, 12, 8'h00, 0, {8'h80, 10'h000, 1'b0, 4'd12, 1'b0});
        directed("swap_st", 8'h83, 1, 8'hC1, 4, {8'hC1, 10'h041, 1'b1, 4'd4, 1'b1});

        c0 = cyc;
        for (int i = 0; i < 8; i++)
            send(8'(8'h80 + i * 13), 4'(i), 8'(8'hF1 - i * 7), 4'(15 - 2 * i));
        chk("throughput", cyc - c0, 8);
        drain();

        o0 = n_out;
        out_ready = 0;
        send(8'hA5, 6, 8'hF3, 1);
        send(8'h9C, 3, 8'hB7, 8);
        fork
            begin
                send(8'hE1, 9, 8'h8F, 9);
                send(8'hC3, 0, 8'hFF, 15);
            end
            begin
                @(negedge clk);
                chk("bp_in_ready", in_ready, 0);
                chk("bp_out_valid", out_valid, 1);
                snap = dut_out();
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_stable", dut_out(), snap);
                end
                @(posedge clk);
                #1 out_ready = 1;
            end
        join
        drain();
        chk("bp_count", n_out - o0, 4);

        out_ready = 0;
        send(8'hAA, 5, 8'h55, 2);
        send(8'hBB, 4, 8'h66, 3);
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", dut_out(), 0);
        chk("mid_rst_ready", in_ready, 1);
        out_ready = 1;
        repeat (5) begin
            @(negedge clk);
            chk("mid_rst_stale", out_valid, 0);
        end
        @(posedge clk);
        #1;
        chk("accounting", n_out + n_drop, n_in);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
